// File: rtl/fetch_controller_if.sv
// fetch_controller_if: fetch/decode/redirect bundle; master = fetch_controller, slave = cache/decode/redirect side; FETCH_STALL_COUNT_EN adds stall_cycles
interface fetch_controller_if;
  logic        redirect_valid;
  logic [14:0] redirect_pc;
  logic [59:0] pc_array_flat;
  logic [63:0] instructions_flat;
  logic [2:0]  out_valid_count;
  logic [63:0] out_instrs_flat;
  logic [59:0] out_pcs_flat;
  logic [2:0]  dec_take;
  logic        halted;
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_cycles;
  modport master(
    input  redirect_valid, redirect_pc, instructions_flat, dec_take,
    output pc_array_flat, out_valid_count, out_instrs_flat, out_pcs_flat, halted, stall_cycles
  );
  modport slave(
    output redirect_valid, redirect_pc, instructions_flat, dec_take,
    input  pc_array_flat, out_valid_count, out_instrs_flat, out_pcs_flat, halted, stall_cycles
  );
`else
  modport master(
    input  redirect_valid, redirect_pc, instructions_flat, dec_take,
    output pc_array_flat, out_valid_count, out_instrs_flat, out_pcs_flat, halted
  );
  modport slave(
    output redirect_valid, redirect_pc, instructions_flat, dec_take,
    input  pc_array_flat, out_valid_count, out_instrs_flat, out_pcs_flat, halted
  );
`endif
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: 4-wide fetch sequencer with circular queue; ports clk, rst (sync active-high), bus (fetch_controller_if.master); FETCH_STALL_COUNT_EN adds bus.stall_cycles
module fetch_controller #(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [14:0] RESET_PC    = 15'h0000
) (
  input logic               clk,
  input logic               rst,
  fetch_controller_if.master bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t ENQ_MAX = cnt_t'(QUEUE_DEPTH - 4);
  logic [15:0] mem_ins_q [QUEUE_DEPTH];
  logic [14:0] mem_pc_q  [QUEUE_DEPTH];
  logic [14:0] fetch_pc_q, fetch_pc_d;
  ptr_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic        halted_q, halted_d;
  logic [14:0] slot_pc  [4];
  logic [15:0] slot_ins [4];
  logic [2:0]  enq_n, ovc, take;
  logic        halt_hit, full, enq_ok;
  for (genvar g = 0; g < 4; g++) begin : g_slot
    assign slot_pc[g]  = fetch_pc_q + 15'(g);
    assign slot_ins[g] = bus.instructions_flat[63-16*g -: 16];
    assign bus.pc_array_flat[59-15*g -: 15]   = slot_pc[g];
    assign bus.out_instrs_flat[63-16*g -: 16] = 3'(g) < ovc ? mem_ins_q[head_q + ptr_t'(g)] : '0;
    assign bus.out_pcs_flat[59-15*g -: 15]    = 3'(g) < ovc ? mem_pc_q[head_q + ptr_t'(g)] : '0;
  end
  always_comb begin
    enq_n    = 3'd4;
    halt_hit = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (slot_ins[i] == 16'hFFFF) begin
        enq_n    = 3'(i + 1);
        halt_hit = 1'b1;
      end
    end
  end
  assign full   = count_q > ENQ_MAX;
  assign enq_ok = !bus.redirect_valid && !halted_q && !full;
  assign ovc    = count_q >= cnt_t'(4) ? 3'd4 : count_q[2:0];
  assign take   = bus.dec_take > ovc ? ovc : bus.dec_take;
  assign bus.out_valid_count = ovc;
  assign bus.halted          = halted_q;
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    halted_d   = halted_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      halted_d   = 1'b0;
    end else begin
      head_d  = head_q + ptr_t'(take);
      count_d = count_q - cnt_t'(take);
      if (enq_ok) begin
        tail_d     = tail_q + ptr_t'(enq_n);
        count_d    = count_d + cnt_t'(enq_n);
        halted_d   = halt_hit;
        fetch_pc_d = halt_hit ? fetch_pc_q : fetch_pc_q + 15'd4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && enq_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < enq_n) begin
          mem_ins_q[tail_q + ptr_t'(i)] <= slot_ins[i];
          mem_pc_q[tail_q + ptr_t'(i)]  <= slot_pc[i];
        end
      end
    end
  end
`ifdef FETCH_STALL_COUNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (!bus.redirect_valid && !halted_q && full && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
  assign bus.stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized and directed checks of fetch_controller against a queue-level reference model
module tb_fetch_controller;
  localparam int D = 8;
  typedef struct packed {
    logic [15:0] ins;
    logic [14:0] pc;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fetch_controller_if bus();
  fetch_controller #(.QUEUE_DEPTH(D), .RESET_PC(15'h0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [15:0] cache [32768];
  always_comb begin
    bus.instructions_flat = '0;
    for (int i = 0; i < 4; i++) bus.instructions_flat[63-16*i -: 16] = cache[bus.pc_array_flat[59-15*i -: 15]];
  end
  ent_t        q[$];
  logic [14:0] m_pc;
  logic        m_halt;
  logic [31:0] m_stall;
  int          total = 0;
  int          bad = 0;
  int          dlv = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic rv, input logic [14:0] rpc, input logic [2:0] tk);
    logic [63:0] ei;
    logic [59:0] ep, ea;
    logic [14:0] a;
    logic        hit, fl;
    int          n, tc;
    ent_t        e;
    rst = r;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.dec_take = tk;
    #1;
    n  = q.size() < 4 ? q.size() : 4;
    ei = '0;
    ep = '0;
    for (int i = 0; i < n; i++) begin
      ei[63-16*i -: 16] = q[i].ins;
      ep[59-15*i -: 15] = q[i].pc;
    end
    for (int i = 0; i < 4; i++) ea[59-15*i -: 15] = m_pc + 15'(i);
    check("valid_cnt", 64'(bus.out_valid_count), 64'(n));
    check("out_instrs", bus.out_instrs_flat, ei);
    check("out_pcs", 64'(bus.out_pcs_flat), 64'(ep));
    check("pc_array", 64'(bus.pc_array_flat), 64'(ea));
    check("halted", 64'(bus.halted), 64'(m_halt));
`ifdef FETCH_STALL_COUNT_EN
    check("stall", 64'(bus.stall_cycles), 64'(m_stall));
`endif
    tc = int'(tk) < n ? int'(tk) : n;
    dlv += tc;
    if (r) begin
      q.delete();
      m_pc = 15'h0000;
      m_halt = 1'b0;
      m_stall = '0;
    end else if (rv) begin
      q.delete();
      m_pc = rpc;
      m_halt = 1'b0;
    end else begin
      fl = q.size() > D - 4;
      if (!m_halt && fl && m_stall != 32'hFFFFFFFF) m_stall++;
      repeat (tc) void'(q.pop_front());
      if (!m_halt && !fl) begin
        hit = 1'b0;
        for (int i = 0; i < 4 && !hit; i++) begin
          a = m_pc + 15'(i);
          e.ins = cache[a];
          e.pc = a;
          q.push_back(e);
          hit = cache[a] == 16'hFFFF;
        end
        if (hit) m_halt = 1'b1;
        else m_pc = m_pc + 15'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) cache[i] = 16'($urandom_range(0, 65534));
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.dec_take = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    q.delete();
    m_pc = 15'h0000;
    m_halt = 1'b0;
    m_stall = '0;
    rst = 1'b0;
    #1;
    check("rst_pc_array", 64'(bus.pc_array_flat), 64'({15'd0, 15'd1, 15'd2, 15'd3}));
    check("rst_valid_cnt", 64'(bus.out_valid_count), 64'd0);
    check("rst_out_instrs", bus.out_instrs_flat, 64'd0);
    step(1'b0, 1'b0, 15'h0, 3'd0);
    check("first_valid_cnt", 64'(bus.out_valid_count), 64'd4);
    check("first_out_pcs", 64'(bus.out_pcs_flat), 64'({15'd0, 15'd1, 15'd2, 15'd3}));
    step(1'b0, 1'b0, 15'h0, 3'd0);
    check("bp_pc_array", 64'(bus.pc_array_flat), 64'({15'd8, 15'd9, 15'd10, 15'd11}));
    repeat (3) step(1'b0, 1'b0, 15'h0, 3'd0);
    check("bp_pc_hold", 64'(bus.pc_array_flat), 64'({15'd8, 15'd9, 15'd10, 15'd11}));
`ifdef FETCH_STALL_COUNT_EN
    check("bp_stall3", 64'(bus.stall_cycles), 64'd3);
`endif
    step(1'b0, 1'b0, 15'h0, 3'd4);
    check("bp_resume_pcs", 64'(bus.out_pcs_flat), 64'({15'd4, 15'd5, 15'd6, 15'd7}));
    step(1'b0, 1'b0, 15'h0, 3'd0);
    check("bp_resume_pc_array", 64'(bus.pc_array_flat), 64'({15'd12, 15'd13, 15'd14, 15'd15}));
    step(1'b1, 1'b0, 15'h0, 3'd0);
    cache[5] = 16'hFFFF;
    dlv = 0;
    repeat (6) step(1'b0, 1'b0, 15'h0, 3'd4);
    check("halt_delivered", 64'(dlv), 64'd6);
    check("halt_flag", 64'(bus.halted), 64'd1);
    check("halt_fetch_pc", 64'(bus.pc_array_flat[59:45]), 64'd4);
    cache[5] = 16'h1234;
    step(1'b0, 1'b1, 15'h7FFE, 3'd0);
    check("wrap_pc_array", 64'(bus.pc_array_flat), 64'({15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001}));
    check("redir_clears_halt", 64'(bus.halted), 64'd0);
    step(1'b0, 1'b0, 15'h0, 3'd0);
    check("wrap_out_pcs", 64'(bus.out_pcs_flat), 64'({15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001}));
    repeat (3) step(1'b0, 1'b0, 15'h0, 3'd0);
    step(1'b0, 1'b1, 15'h0100, 3'd3);
    check("redir_valid_cnt", 64'(bus.out_valid_count), 64'd0);
    step(1'b0, 1'b0, 15'h0, 3'd0);
    check("redir_out_pcs", 64'(bus.out_pcs_flat), 64'({15'h100, 15'h101, 15'h102, 15'h103}));
    step(1'b0, 1'b0, 15'h0, 3'd0);
    step(1'b0, 1'b0, 15'h0, 3'd4);
    step(1'b0, 1'b0, 15'h0, 3'd3);
    step(1'b0, 1'b0, 15'h0, 3'd3);
    check("clamp_valid_cnt", 64'(bus.out_valid_count), 64'd2);
    step(1'b0, 1'b0, 15'h0, 3'd4);
    check("clamp_after_cnt", 64'(bus.out_valid_count), 64'd4);
    repeat (300) cache[$urandom_range(0, 32767)] = 16'hFFFF;
    repeat (800) begin
      step($urandom % 60 == 0, $urandom % 10 == 0,
           $urandom % 3 == 0 ? 15'h7FFC + 15'($urandom % 4) : 15'($urandom),
           3'($urandom % 5));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Front-end fetch sequencer for the 4-wide instruction cache. Each cycle it drives four consecutive word addresses into the cache and captures the four returned instructions into a circular fetch queue. It hands up to four queued instructions per cycle to decode, and handles redirects (flush plus new PC) and halt detection. It sits between the branch/commit redirect logic and the decode stage.

## Interface
- `QUEUE_DEPTH`, 8: fetch queue entries; power of two, ≥ 8.
- `RESET_PC`, 15'h0000: word address fetched after reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `redirect_valid`  in  1  flush queue and restart fetch at `redirect_pc`.
- `redirect_pc`  in  15  word address of the redirect target.
- `pc_array_flat`  out  60  four fetch word addresses to the cache; slot 0 in [59:45], slot 3 in [14:0].
- `instructions_flat`  in  64  cache read data, same cycle; slot 0 in [63:48], slot 3 in [15:0].
- `out_valid_count`  out  3  number of valid instructions presented to decode (0..4).
- `out_instrs_flat`  out  64  queue head instructions; slot 0 (oldest) in [63:48].
- `out_pcs_flat`  out  60  word addresses of the presented instructions; slot 0 in [59:45].
- `dec_take`  in  3  instructions decode consumes this cycle (0..4).
- `halted`  out  1  a halt word (16'hFFFF) was enqueued; fetch is stopped.
- `stall_cycles`  out  32  fetch stall counter; present only with `FETCH_STALL_COUNT_EN`.

## Operation
- **Fetch PC.** `fetch_pc` register; `pc_array_flat` slots are `fetch_pc`, +1, +2, +3, each computed modulo 2^15 (wraps 15'h7FFF→15'h0000).
- **Enqueue condition.** Enqueue happens when all of the following hold: `!rst`, `!redirect_valid`, `!halted`, and `count ≤ QUEUE_DEPTH-4`. `count` is the pre-dequeue value.
- **Enqueue.** Each entry stores {instruction, word address}.
  - Normal case: four entries are written at the tail, then `fetch_pc += 4`, tail advances 4.
  - Halt case: if any slot holds 16'hFFFF, only slots up to and including the first such slot are written. `halted` sets next cycle and `fetch_pc` holds.
- **Dequeue.**
  - `out_valid_count = min(count, 4)`.
  - Slots ≥ `out_valid_count` drive all-zero instructions and PCs.
  - `dec_take` is clamped to `out_valid_count`. The head advances by the clamped value.
- **Count update.** `count_next = count + enq_n − take_clamped`. Simultaneous enqueue and dequeue are legal. Head and tail wrap modulo `QUEUE_DEPTH`.
- **Redirect.** Redirect overrides enqueue and dequeue that cycle:
  - count, head and tail are set to 0;
  - `fetch_pc ← redirect_pc`;
  - `halted ← 0`;
  - `dec_take` is ignored.
- **Reset.** Reset has priority over redirect:
  - `fetch_pc = RESET_PC`, count/head/tail = 0, `halted = 0`;
  - the stall counter clears;
  - outputs after reset: `out_valid_count = 0`, `out_instrs_flat = 0`, `out_pcs_flat = 0`, `pc_array_flat = {RESET_PC, +1, +2, +3}`.
- **Mid-operation reset.** Reset asserted mid-operation discards all queued entries.

## Timing
- Cache read is combinational. The instructions for the addresses driven in cycle N are captured at the end of cycle N.
- Fetch-to-decode latency is 1 cycle: instructions fetched in cycle N appear at the queue outputs in cycle N+1.
- Redirect asserted in cycle N:
  - `out_valid_count = 0` in N+1;
  - `pc_array_flat` shows `redirect_pc` in N+1;
  - target instructions are visible in N+2.
- When the queue is full (`count > QUEUE_DEPTH-4`), fetch stalls: `fetch_pc` holds. With `dec_take` of 4 in cycle N, enqueue resumes in N+1.
- `halted` rises the cycle after the halt word is enqueued. It stays high until `rst` or `redirect_valid`.

## Configuration
- Macro: `FETCH_STALL_COUNT_EN`.
- **Defined.** `stall_cycles` is a 32-bit counter.
  - It increments each cycle in which none of `rst`, `redirect_valid` or `halted` is asserted and the enqueue condition fails because the queue is full.
  - It saturates at 32'hFFFFFFFF.
  - It clears on `rst` only.
- **Undefined.** The port and counter are absent. All other behaviour is identical.

## Test plan
- **Reset.** Hold `rst` 2 cycles with `RESET_PC` = 0, then release. Required: `pc_array_flat` slots 0,1,2,3; `out_valid_count` = 0 in the first cycle, and 4 in the next cycle with `out_pcs` 0,1,2,3.
- **Backpressure.** Hold `dec_take` = 0. Required: count reaches 8, `pc_array_flat` holds at 8,9,10,11, and `stall_cycles` increments 1 per cycle. Then set `dec_take` = 4 for 1 cycle. Required: fetch resumes and `out_pcs` = 4..7.
- **Halt.** Place 16'hFFFF at word 5 and use `dec_take` = 4. Required: exactly 6 instructions are delivered (PCs 0..5), `halted` = 1, and `fetch_pc` holds at 4.
- **Wrap.** Redirect to 15'h7FFE. Required: `pc_array_flat` = 7FFE, 7FFF, 0000, 0001 next cycle, and `out_pcs` match one cycle later.
- **Redirect vs dequeue.** `redirect_valid` = 1 to 15'h0100 while the queue is full and `dec_take` = 3. Required: next cycle `out_valid_count` = 0; cycle after, `out_pcs` = 0x100..0x103.
- **Clamp.** With `count` = 2, drive `dec_take` = 4. Required: `out_valid_count` = 2, only 2 instructions are consumed, and no underflow (next count = 0 + enqueued 4).
